// File: rtl/alu_issue_if.sv
// Command, ALU-drive and response signals of the alu_issue block.
// The slave view is the issuer itself; the master view is the front end
// (command producer / response consumer) that also owns the ALU result.
interface alu_issue_if #(parameter int REG_AW = 2);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rs;
  logic [REG_AW-1:0] cmd_rt;
  logic [REG_AW-1:0] cmd_rd;
  logic [31:0]       cmd_imm;
  logic [31:0]       alu_A;
  logic [31:0]       alu_B;
  logic [2:0]        alu_op;
  logic [31:0]       alu_C;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, alu_C, rsp_ready,
    output cmd_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, alu_C, rsp_ready,
    input  cmd_ready, alu_A, alu_B, alu_op, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_issue.sv
// Command-driven initiator for a 32-bit combinational ALU.
// Holds a 2^REG_AW x 32 register file, takes one command at a time, drives
// the ALU for a single cycle and returns the result on a response channel.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | cmd_ready high; a valid command is latched with its operands
//   EXEC  | ALU inputs driven from latched operands; result captured
//   RESP  | rsp_valid high until the consumer takes it
module alu_issue #(
  parameter int REG_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [2:0] OP_LAST_ALU = 3'd5;
  localparam logic [2:0] OP_LOAD     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [31:0]       r_imm;
  logic [31:0]       r_src_a;
  logic [31:0]       r_rf [NREG];
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [31:0]       r_alu_A;
  logic [31:0]       r_alu_B;
  logic [2:0]        r_alu_op;

  logic w_cmd_is_alu;
  logic w_exec_is_alu;

  assign w_cmd_is_alu  = (bus.cmd_op <= OP_LAST_ALU);
  assign w_exec_is_alu = (r_op <= OP_LAST_ALU);

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.alu_A     = r_alu_A;
  assign bus.alu_B     = r_alu_B;
  assign bus.alu_op    = r_alu_op;

  // Sequencer: command latch, ALU drive, writeback and response handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_src_a     <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_alu_op    <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            // Operands are sampled here, so a source equal to rd sees the
            // value from before this command's own writeback.
            r_op        <= bus.cmd_op;
            r_rd        <= bus.cmd_rd;
            r_imm       <= bus.cmd_imm;
            r_src_a     <= r_rf[bus.cmd_rs];
            r_cmd_ready <= 1'b0;
            r_state     <= ST_EXEC;
            if (w_cmd_is_alu) begin
              r_alu_A  <= r_rf[bus.cmd_rs];
              r_alu_B  <= r_rf[bus.cmd_rt];
              r_alu_op <= bus.cmd_op;
            end
          end
        end

        ST_EXEC: begin
          if (w_exec_is_alu) begin
            r_rsp_data <= bus.alu_C;
            r_rf[r_rd] <= bus.alu_C;
          end else if (r_op == OP_LOAD) begin
            r_rsp_data <= r_imm;
            r_rf[r_rd] <= r_imm;
          end else begin
            r_rsp_data <= r_src_a;
          end
          r_alu_A     <= '0;
          r_alu_B     <= '0;
          r_alu_op    <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_alu_A     <= '0;
          r_alu_B     <= '0;
          r_alu_op    <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
